// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates icache/dcache word requests onto a single-port RAM.
// Define MEM_ARB_PERF_EN for completion counters and a starvation pulse output.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate,
  output logic        mem_err
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0] icnt,
  output logic [31:0] dcnt,
  output logic        starve_evt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    DACC = 2'b01,
    IACC = 2'b10
  } state_e;

  localparam logic [1:0] RS_ACCESS = 2'b10;
  localparam logic [1:0] RS_ERROR  = 2'b11;
  localparam logic [4:0] LIMIT     = 5'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       err_q, err_d;
  logic       dreq;
  logic       access;
  logic       force_i;
  logic [4:0] starve_inc;

  assign dreq       = dREN | dWEN;
  assign access     = (ramstate == RS_ACCESS);
  assign starve_inc = {1'b0, starve_q} + 5'd1;

  always_comb begin
    state_d  = state_q;
    starve_d = starve_q;
    err_d    = err_q;
    force_i  = 1'b0;
    iwait    = 1'b1;
    dwait    = 1'b1;
    iload    = '0;
    dload    = '0;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    unique case (state_q)
      IDLE: begin
        if (dreq)      state_d = DACC;
        else if (iREN) state_d = IACC;
      end
      DACC: begin
        ramaddr  = daddr;
        ramstore = dstore;
        ramWEN   = dWEN;
        ramREN   = dREN & ~dWEN;
        if (ramstate == RS_ERROR) err_d = 1'b1;
        if (access) begin
          dwait = 1'b0;
          dload = ramload;
          if (iREN) begin
            starve_d = (starve_q == 4'hF) ? 4'hF : starve_inc[3:0];
            // icache has waited long enough: hand it the next grant
            if (starve_inc >= LIMIT) begin
              force_i  = 1'b1;
              starve_d = '0;
            end
          end else begin
            starve_d = '0;
          end
        end
        if (force_i)   state_d = IACC;
        else if (!dreq) state_d = iREN ? IACC : IDLE;
      end
      IACC: begin
        ramREN  = iREN;
        ramaddr = iaddr;
        iload   = ramload;
        if (ramstate == RS_ERROR) err_d = 1'b1;
        if (access) begin
          iwait = 1'b0;
          if (dreq)      state_d = DACC;
          else if (iREN) state_d = IACC;
          else           state_d = IDLE;
        end else if (!iREN) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  assign mem_err = err_q;

`ifdef MEM_ARB_PERF_EN
  logic [31:0] icnt_q, dcnt_q;
  logic        evt_q;
  logic        icomp, dcomp;

  assign icomp = (state_q == IACC) & access;
  assign dcomp = (state_q == DACC) & access;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      icnt_q <= '0;
      dcnt_q <= '0;
      evt_q  <= 1'b0;
    end else begin
      icnt_q <= icnt_q + 32'(icomp);
      dcnt_q <= dcnt_q + 32'(dcomp);
      evt_q  <= force_i;
    end
  end

  assign icnt       = icnt_q;
  assign dcnt       = dcnt_q;
  assign starve_evt = evt_q;
`endif

endmodule
